// File: rtl/ibex_rf_dump_reader.sv
// ibex_rf_dump_reader
// Walks every architectural register through one combinational register-file
// read port and streams {address, data} beats out on a valid/ready interface.
// A single output register stage decouples the read port from the sink; the
// read pointer only advances when that stage can take a new beat.

module ibex_rf_dump_reader #(
   parameter int unsigned RV32E     = 0,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned SkipR0    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [4:0]           raddr_o,
   input  logic [DataWidth-1:0] rdata_i,
   output logic                 dump_valid_o,
   input  logic                 dump_ready_i,
   output logic [4:0]           dump_addr_o,
   output logic [DataWidth-1:0] dump_data_o,
   output logic                 dump_last_o
);

   localparam int unsigned AddrWidth = (RV32E != 0) ? 4 : 5;
   localparam int unsigned NumWords  = 2 ** AddrWidth;
   localparam logic [4:0]  FirstAddr = (SkipR0 != 0) ? 5'd1 : 5'd0;
   localparam logic [4:0]  LastAddr  = 5'(NumWords - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      LAST = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [4:0]           ptr_q, ptr_d;
   logic                 valid_q, valid_d;
   logic [4:0]           addr_q, addr_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 last_q, last_d;
   logic                 done_q, done_d;

   logic                 handshake;
   logic                 slot_free;

   assign handshake = valid_q & dump_ready_i;
   // The slot can take a new beat when empty or when its beat leaves this cycle.
   assign slot_free = ~valid_q | dump_ready_i;

   // Next-state, pointer and output-slot logic.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d = state_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last_d  = last_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               ptr_d   = FirstAddr;
               state_d = READ;
            end
         end

         READ: begin
            if (abort_i) begin
               // Abort beats any same-cycle handshake; the in-flight beat is dropped.
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (slot_free) begin
               valid_d = 1'b1;
               addr_d  = ptr_q;
               data_d  = rdata_i;
               last_d  = (ptr_q == LastAddr);
               if (ptr_q == LastAddr) begin
                  // Pointer parks on the last register so raddr_o holds it afterwards.
                  state_d = LAST;
               end else begin
                  ptr_d = ptr_q + 5'd1;
               end
            end
         end

         LAST: begin
            if (abort_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (handshake) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, pointer and output-slot registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= 5'd0;
         valid_q <= 1'b0;
         addr_q  <= 5'd0;
         data_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign raddr_o      = ptr_q;
   assign dump_valid_o = valid_q;
   assign dump_addr_o  = addr_q;
   assign dump_data_o  = data_q;
   assign dump_last_o  = last_q;

endmodule

// File: tb/tb_ibex_rf_dump_reader.sv
// Testbench for ibex_rf_dump_reader: two instances (RV32I skipping x0, and
// RV32E including x0) driven with randomized backpressure. Expected beats are
// queued when a start is accepted and compared by per-instance monitors.

module tb_ibex_rf_dump_reader;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Instance A: RV32I, SkipR0=1 -> 31 beats, x1..x31
   logic        start_a = 0, abort_a = 0, ready_a = 0;
   logic        busy_a, done_a, valid_a, last_a;
   logic [4:0]  raddr_a, addr_a;
   logic [31:0] rdata_a, data_a;
   logic [31:0] rf_a [32];
   assign rdata_a = rf_a[raddr_a];

   // Instance B: RV32E, SkipR0=0 -> 16 beats, x0..x15
   logic        start_b = 0, abort_b = 0, ready_b = 0;
   logic        busy_b, done_b, valid_b, last_b;
   logic [4:0]  raddr_b, addr_b;
   logic [31:0] rdata_b, data_b;
   logic [31:0] rf_b [16];
   assign rdata_b = rf_b[raddr_b[3:0]];

   ibex_rf_dump_reader #(.RV32E(0), .DataWidth(32), .SkipR0(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort_a),
      .busy_o(busy_a), .done_o(done_a), .raddr_o(raddr_a), .rdata_i(rdata_a),
      .dump_valid_o(valid_a), .dump_ready_i(ready_a), .dump_addr_o(addr_a),
      .dump_data_o(data_a), .dump_last_o(last_a)
   );

   ibex_rf_dump_reader #(.RV32E(1), .DataWidth(32), .SkipR0(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort_b),
      .busy_o(busy_b), .done_o(done_b), .raddr_o(raddr_b), .rdata_i(rdata_b),
      .dump_valid_o(valid_b), .dump_ready_i(ready_b), .dump_addr_o(addr_b),
      .dump_data_o(data_b), .dump_last_o(last_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- Monitor / scoreboard for instance A ----------------
   beat_t q_a[$];
   int    cyc_a = 0, start_cyc_a = 0, stalls_a = 0, dumps_a = 0;
   bit    done_exp_a = 0, post_start_a = 0, post_abort_a = 0, prev_stall_a = 0, prev_busy_a = 0;
   logic [4:0] prev_raddr_a = 5'd0;

   always @(negedge clk) begin
      cyc_a++;
      if (rst) begin
         q_a.delete();
         done_exp_a = 0; post_start_a = 0; post_abort_a = 0; prev_stall_a = 0;
         prev_busy_a = 0; prev_raddr_a = 5'd0;
      end else begin
         check("a_done", done_a, done_exp_a);
         if (done_a) begin
            check("a_done_latency", cyc_a - start_cyc_a, 31 + 2 + stalls_a);
            check("a_raddr_after_dump", raddr_a, 31);
            dumps_a++;
         end
         if (post_start_a) begin
            check("a_busy_after_start", busy_a, 1);
            check("a_raddr_first", raddr_a, 1);
         end
         if (post_abort_a) check("a_after_abort", {valid_a, busy_a, done_a}, 3'b000);
         if (prev_stall_a) check("a_valid_held", valid_a, 1);
         if (!busy_a && !prev_busy_a) check("a_raddr_hold", raddr_a, prev_raddr_a);
         if (valid_a) begin
            if (q_a.size() == 0) check("a_unexpected_beat", {addr_a, data_a, last_a}, 0);
            else check("a_beat", {addr_a, data_a, last_a}, q_a[0]);
         end

         done_exp_a = 0; post_start_a = 0; post_abort_a = 0;
         if (busy_a && abort_a) begin
            q_a.delete();
            post_abort_a = 1;
         end else begin
            if (valid_a && !ready_a) stalls_a++;
            if (valid_a && ready_a && q_a.size() > 0) begin
               beat_t b;
               b = q_a.pop_front();
               if (b.last) done_exp_a = 1;
            end
         end
         if (!busy_a && start_a && !abort_a) begin
            for (int i = 1; i < 32; i++) q_a.push_back('{addr: 5'(i), data: rf_a[i], last: (i == 31)});
            post_start_a = 1;
            start_cyc_a  = cyc_a;
            stalls_a     = 0;
         end
         prev_stall_a = valid_a && !ready_a && !abort_a;
         prev_busy_a  = busy_a;
         prev_raddr_a = raddr_a;
      end
   end

   // ---------------- Monitor / scoreboard for instance B ----------------
   beat_t q_b[$];
   int    cyc_b = 0, start_cyc_b = 0, stalls_b = 0;
   bit    done_exp_b = 0, post_start_b = 0;

   always @(negedge clk) begin
      cyc_b++;
      if (rst) begin
         q_b.delete();
         done_exp_b = 0; post_start_b = 0;
      end else begin
         check("b_done", done_b, done_exp_b);
         if (done_b) check("b_done_latency", cyc_b - start_cyc_b, 16 + 2 + stalls_b);
         if (post_start_b) check("b_raddr_first", {busy_b, raddr_b}, {1'b1, 5'd0});
         if (busy_b) check("b_raddr_upper_zero", raddr_b[4], 0);
         if (valid_b) begin
            if (q_b.size() == 0) check("b_unexpected_beat", {addr_b, data_b, last_b}, 0);
            else check("b_beat", {addr_b, data_b, last_b}, q_b[0]);
         end

         done_exp_b = 0; post_start_b = 0;
         if (valid_b && !ready_b) stalls_b++;
         if (valid_b && ready_b && q_b.size() > 0) begin
            beat_t b;
            b = q_b.pop_front();
            if (b.last) done_exp_b = 1;
         end
         if (!busy_b && start_b) begin
            for (int i = 0; i < 16; i++) q_b.push_back('{addr: 5'(i), data: rf_b[i], last: (i == 15)});
            post_start_b = 1;
            start_cyc_b  = cyc_b;
            stalls_b     = 0;
         end
      end
   end

   // ---------------- Stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic pick_ready(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return ((k % 4) == 0) || ((k % 4) == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Start the selected instances in cycle 0, apply ready patterns, optionally
   // abort A in cycle abort_at, and run until both are idle (bounded).
   task automatic dump(input int mode_a, input int mode_b, input bit go_a, input bit go_b,
                       input int abort_at);
      int k = 0;
      start_a = go_a;
      start_b = go_b;
      do begin
         ready_a = pick_ready(mode_a, k);
         ready_b = pick_ready(mode_b, k);
         abort_a = (k == abort_at);
         step();
         k++;
         start_a = 0;
         start_b = 0;
         abort_a = 0;
      end while ((busy_a || busy_b) && k < 2000);
      check("dump_terminates", k < 2000, 1);
      ready_a = 1;
      ready_b = 1;
      step();
      step();
   endtask

   task automatic randomize_rf();
      for (int i = 0; i < 32; i++) rf_a[i] = $urandom;
      for (int i = 0; i < 16; i++) rf_b[i] = $urandom;
      rf_a[0] = 32'd0;
      rf_b[0] = 32'd0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_a[i] = 32'h1000 + 32'(i);
      for (int i = 0; i < 16; i++) rf_b[i] = (i == 0) ? 32'd0 : $urandom;

      #1 rst = 1'b1;
      #2;
      check("reset_outputs_a", {busy_a, done_a, raddr_a, valid_a, addr_a, data_a, last_a}, 0);
      check("reset_outputs_b", {busy_b, done_b, raddr_b, valid_b, addr_b, data_b, last_b}, 0);
      step();
      step();
      rst = 1'b0;
      step();

      // Full dumps with ready held high on both instances
      dump(0, 0, 1, 1, -1);
      check("a_dump_count_1", dumps_a, 1);

      // Ready toggling 1,0,0,1 on A, random on B
      dump(1, 2, 1, 1, -1);

      // Abort A in cycle 10, then a fresh dump from x1
      dump(0, 0, 1, 0, 10);
      dump(0, 0, 1, 0, -1);

      // start held high: back-to-back dumps, start while busy ignored
      start_a = 1;
      for (int k = 0; k < 150; k++) begin
         ready_a = pick_ready(2, k);
         step();
      end
      start_a = 0;
      dump(2, 0, 0, 0, -1);

      // Reset asserted mid-stall with a valid beat pending
      start_a = 1;
      ready_a = 1;
      step();
      start_a = 0;
      repeat (4) step();
      ready_a = 0;
      repeat (3) step();
      check("a_valid_before_reset", valid_a, 1);
      #1 rst = 1'b1;
      #1;
      check("reset_mid_dump", {busy_a, done_a, raddr_a, valid_a, addr_a, data_a, last_a}, 0);
      step();
      step();
      rst = 1'b0;
      ready_a = 1;
      repeat (40) step();
      check("a_idle_after_reset", busy_a, 0);

      // Randomized dumps with random contents, backpressure and aborts
      for (int r = 0; r < 8; r++) begin
         randomize_rf();
         dump(2, 2, 1, 1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1);
      end

      check("a_queue_empty", q_a.size(), 0);
      check("b_queue_empty", q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
